ahb_fifo_core: RTL

AHB_FIFO_CORE -- requirements
Module: ahb_fifo_core

---
 rtl/ahb_fifo_core.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ahb_fifo_core.sv
// ahb_fifo_core -- synchronous FIFO sitting behind an AHB slave interface.
//
// One storage word per slot, pointers carry an extra wrap bit so full and
// empty come straight from pointer comparison. Pop data is registered, so a
// word appears on rdata with rvalid one cycle after the accepted fiford.
//
// Ports:
//   hclk, hreset   clock, synchronous active-high reset
//   fifowr, wdata  push request and data
//   fiford         pop request
//   rdata, rvalid  registered pop data and its valid strobe
//   full, empty    occupancy flags (from registered pointers)
//   almost_full    count >= AF_LEVEL (registered)
//   almost_empty   count <= AE_LEVEL (registered)
//   count          occupancy 0..DEPTH
//   err_clr        clears sticky error flags
//   overflow       sticky: push rejected
//   underflow      sticky: pop rejected
//
// Build option: define FIFO_ERR_FLAGS_EN to get the sticky overflow/underflow
// registers; otherwise they are tied low and err_clr is ignored.

module ahb_fifo_core #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = (1 << AWIDTH) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              fifowr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              fiford,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q,  count_d;
    logic [DWIDTH-1:0] rdata_q;
    logic              rvalid_q;
    logic              af_q, ae_q;
    logic              push, pop;

    assign full  = (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]) &&
                   (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // fine when it is paired with a pop.
    assign pop  = fiford && !empty;
    assign push = fifowr && (!full || pop);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge hclk) begin
        if (push) mem[wr_ptr_q[AWIDTH-1:0]] <= wdata;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rvalid_q <= pop;
            if (pop) rdata_q <= mem[rd_ptr_q[AWIDTH-1:0]];
            af_q     <= (int'(count_d) >= AF_LEVEL);
            ae_q     <= (int'(count_d) <= AE_LEVEL);
        end
    end

    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign count        = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    // Setting wins over clearing in the same cycle.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (fifowr && !push) ovf_q <= 1'b1;
            else if (err_clr)    ovf_q <= 1'b0;
            if (fiford && !pop)  udf_q <= 1'b1;
            else if (err_clr)    udf_q <= 1'b0;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
